dbridge_fsm: RTL and testbench

DBRIDGE_FSM -- requirements
Module: dbridge_fsm

---
 rtl/dbridge_fsm_pkg.sv | 31 +++
 rtl/dbridge_addr_map.sv | 19 +
 rtl/dbridge_fsm.sv | 117 +++++++++++
 tb/tb_dbridge_fsm.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dbridge_fsm_pkg.sv
// Shared definitions for the CPU data-side bus bridge: FSM states, bus size
// codes and the store-size decode.
package dbridge_fsm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // kseg0/kseg1 alias physical memory from address zero
    localparam logic [31:0] KSEG_UNMAP_MASK = 32'h1FFF_FFFF;

    // Stores encode their width in the byte-select pattern; loads carry it explicitly.
    function automatic logic [1:0] bus_size(input logic [3:0] wen, input logic [1:0] size);
        logic [1:0] s;
        case (wen)
            4'b0000:                             s = size;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: s = SIZE_B;
            4'b0011, 4'b1100:                    s = SIZE_H;
            default:                             s = SIZE_W;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/dbridge_addr_map.sv
// Fixed MIPS virtual-to-physical mapping for the data bus (combinational).
// Used by dbridge_fsm only when DBRIDGE_ADDR_MAP_EN is defined; ADDR_W >= 32.
module dbridge_addr_map
    import dbridge_fsm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    output logic [ADDR_W-1:0] o_addr
);

    always_comb begin
        o_addr = i_addr;
        if (i_addr[31:30] == 2'b10) begin
            o_addr[31:0] = i_addr[31:0] & KSEG_UNMAP_MASK;
        end
    end

endmodule

// File: rtl/dbridge_fsm.sv
// MEM-stage to SRAM-like data bus bridge: one outstanding transaction, pipeline stall.
// Optional build macro DBRIDGE_ADDR_MAP_EN enables kseg0/kseg1 address mapping.
module dbridge_fsm
    import dbridge_fsm_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [1:0]        mem_size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [31:0]       mem_rdata,
    output logic              stall_o,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    state_t            r_state;
    logic              r_kill;
    logic              r_req;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              w_start;
    logic [ADDR_W-1:0] w_data_addr;

    assign w_start = mem_en & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_kill  <= 1'b0;
            r_req   <= 1'b0;
            r_wr    <= 1'b0;
            r_size  <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= ADDR;
                        r_req   <= 1'b1;
                        r_wr    <= |mem_wen;
                        r_size  <= bus_size(mem_wen, mem_size);
                        r_addr  <= mem_addr;
                        r_wdata <= mem_wdata;
                        r_kill  <= 1'b0;
                    end
                end
                ADDR: begin
                    // A flushed instruction still owns the bus until its handshake ends
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (data_addr_ok) begin
                        r_req   <= 1'b0;
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (data_data_ok) begin
                        if (r_kill || flush) begin
                            r_state <= IDLE;
                        end else begin
                            r_state <= DONE;
                            if (!r_wr) begin
                                r_rdata <= data_rdata;
                            end
                        end
                        r_kill <= 1'b0;
                    end else if (flush) begin
                        r_kill <= 1'b1;
                    end
                end
                DONE: begin
                    if (flush || !ext_stall) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DBRIDGE_ADDR_MAP_EN
    dbridge_addr_map #(.ADDR_W(ADDR_W)) u_addr_map (
        .i_addr (r_addr),
        .o_addr (w_data_addr)
    );
`else
    assign w_data_addr = r_addr;
`endif

    assign stall_o    = ((r_state == IDLE) & w_start) | (r_state == ADDR) | (r_state == DATA);
    assign data_req   = r_req;
    assign data_wr    = r_wr;
    assign data_size  = r_size;
    assign data_addr  = w_data_addr;
    assign data_wdata = r_wdata;
    assign mem_rdata  = r_rdata;

endmodule

// File: tb/tb_dbridge_fsm.sv
// Self-checking bench for dbridge_fsm: directed vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_dbridge_fsm;

    localparam int ADDR_W = 32;

`ifdef DBRIDGE_ADDR_MAP_EN
    localparam logic [31:0] BFC_EXP = 32'h1FC0_0100;
`else
    localparam logic [31:0] BFC_EXP = 32'hBFC0_0100;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              flush;
    logic              ext_stall;
    logic [31:0]       mem_rdata;
    logic              stall_o;
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    dbridge_fsm #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .flush        (flush),
        .ext_stall    (ext_stall),
        .mem_rdata    (mem_rdata),
        .stall_o      (stall_o),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    // aw: extra cycles before addr_ok; dd: cycles from addr_ok to data_ok (>=1);
    // es: DONE cycles held by ext_stall; fl: flush in 1=ADDR, 2=DATA; fdone: flush exits DONE
    typedef struct {
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aw;
        int          dd;
        int          es;
        int          fl;
        bit          fdone;
        bit          noise;
        logic [1:0]  exp_size;
        logic        exp_wr;
        logic [31:0] exp_addr;
        int          exp_stall;
        int          exp_req;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_rdata = '0;
    vec_t        tbl[12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] wen, input logic [1:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int aw, input int dd,
                                input int es, input int fl, input bit fdone, input bit noise,
                                input logic [1:0] exp_size, input logic exp_wr,
                                input logic [31:0] exp_addr, input int exp_stall,
                                input int exp_req);
        vec_t v;
        v.wen = wen; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.aw = aw; v.dd = dd; v.es = es; v.fl = fl; v.fdone = fdone; v.noise = noise;
        v.exp_size = exp_size; v.exp_wr = exp_wr; v.exp_addr = exp_addr;
        v.exp_stall = exp_stall; v.exp_req = exp_req;
        return v;
    endfunction

    // Reference rules written from the bus protocol description
    function automatic logic [1:0] model_size(input logic [3:0] wen, input logic [1:0] size);
        if (wen == 4'b0000) return size;
        if ($countones(wen) == 1) return 2'd0;
        if ($countones(wen) == 2) return 2'd1;
        return 2'd2;
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef DBRIDGE_ADDR_MAP_EN
        if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a % 32'h2000_0000;
`endif
        return a;
    endfunction

    task automatic idle_inputs();
        mem_en = 1'b0; mem_wen = '0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        flush = 1'b0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    endtask

    task automatic garbage_fields();
        mem_wen   = 4'($urandom_range(0, 15));
        mem_size  = 2'($urandom_range(0, 3));
        mem_addr  = $urandom;
        mem_wdata = $urandom;
    endtask

    // ext_stall=1 here keeps a wrongly-lingering DONE visible to the next start check
    task automatic post_cycle(input string name);
        @(negedge clk);
        idle_inputs();
        ext_stall = 1'b1;
        #1;
        check(name, {stall_o, data_req, mem_rdata}, {1'b0, 1'b0, exp_rdata});
    endtask

    task automatic check_reset_state(input string name);
        check(name, {stall_o, data_req, data_wr, data_size, data_addr, data_wdata, mem_rdata},
              '0);
    endtask

    task automatic run_txn(input vec_t t);
        int ph = 0;
        int pc = 0;
        int stall_cnt = 0;
        int req_cnt = 0;
        bit kill = (t.fl != 0);
        while (ph < 3) begin
            @(negedge clk);
            mem_en    = 1'b1;
            ext_stall = (t.es > 0);
            if (ph == 0) begin
                mem_wen = t.wen; mem_size = t.size; mem_addr = t.addr; mem_wdata = t.wdata;
            end else begin
                garbage_fields();
            end
            flush        = (t.fl == 1 && ph == 1 && pc == 0) || (t.fl == 2 && ph == 2 && pc == 0);
            data_addr_ok = (ph == 1 && pc == t.aw);
            data_data_ok = (ph == 2 && pc == t.dd - 1);
            data_rdata   = data_data_ok ? t.rdata : $urandom;
            if (t.noise) begin
                if (ph == 2 || ph == 0) data_addr_ok = 1'($urandom_range(0, 1));
                if ((ph == 1 && pc != t.aw) || ph == 0) data_data_ok = 1'($urandom_range(0, 1));
            end
            #1;
            if (ph == 0) check("start_stall", stall_o, 1'b1);
            stall_cnt += int'(stall_o);
            req_cnt   += int'(data_req);
            if (data_req) begin
                check("bus_fields", {data_wr, data_size, data_addr, data_wdata},
                      {t.exp_wr, t.exp_size, t.exp_addr, t.wdata});
            end
            if (ph == 0) begin
                ph = 1; pc = 0;
            end else if (ph == 1) begin
                if (pc == t.aw) begin ph = 2; pc = 0; end else pc++;
            end else begin
                if (pc == t.dd - 1) ph = 3; else pc++;
            end
        end
        if (!kill) begin
            if (t.wen == 4'b0000) exp_rdata = t.rdata;
            for (int k = 0; k <= t.es; k++) begin
                @(negedge clk);
                mem_en       = 1'b1;
                garbage_fields();
                ext_stall    = (k < t.es) || t.fdone;
                flush        = (k == t.es) && t.fdone;
                data_addr_ok = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                data_data_ok = t.noise ? 1'($urandom_range(0, 1)) : 1'b0;
                data_rdata   = $urandom;
                #1;
                stall_cnt += int'(stall_o);
                check("done_hold", {data_req, mem_rdata}, {1'b0, exp_rdata});
            end
        end
        post_cycle("post_idle");
        check("stall_cycles", stall_cnt, t.exp_stall);
        check("req_cycles", req_cnt, t.exp_req);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [3:0] wen_set[10];
        wen_set = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
                    4'b0011, 4'b1100, 4'b1111};

        // wen, size, addr, wdata, rdata, aw, dd, es, fl, fdone, noise | size, wr, addr, stall, req
        tbl[0]  = mk(4'b0000, 2'd2, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, 0, 2'd2, 1'b0, 32'h0000_0010, 3, 1);
        tbl[1]  = mk(4'b0100, 2'd0, 32'h0000_0012, 32'h5A5A_5A5A, 32'h0, 0, 1, 0, 0, 0, 0, 2'd0, 1'b1, 32'h0000_0012, 3, 1);
        tbl[2]  = mk(4'b0000, 2'd1, 32'h0000_0022, 32'h0, 32'h0000_CAFE, 4, 3, 0, 0, 0, 0, 2'd1, 1'b0, 32'h0000_0022, 9, 5);
        tbl[3]  = mk(4'b0000, 2'd2, 32'h0000_0040, 32'h0, 32'h0BAD_F00D, 0, 1, 3, 0, 0, 0, 2'd2, 1'b0, 32'h0000_0040, 3, 1);
        tbl[4]  = mk(4'b0000, 2'd2, 32'hBFC0_0100, 32'h0, 32'h0123_4567, 1, 1, 0, 0, 0, 0, 2'd2, 1'b0, BFC_EXP, 4, 2);
        tbl[5]  = mk(4'b1100, 2'd0, 32'h0000_0102, 32'hA5A5_A5A5, 32'h0, 0, 2, 0, 0, 0, 0, 2'd1, 1'b1, 32'h0000_0102, 4, 1);
        tbl[6]  = mk(4'b1111, 2'd0, 32'h0000_0200, 32'h1122_3344, 32'h0, 1, 1, 1, 0, 0, 0, 2'd2, 1'b1, 32'h0000_0200, 4, 2);
        tbl[7]  = mk(4'b0000, 2'd2, 32'h0000_0300, 32'h0, 32'h1234_5678, 0, 2, 0, 2, 0, 0, 2'd2, 1'b0, 32'h0000_0300, 4, 1);
        tbl[8]  = mk(4'b0000, 2'd0, 32'h0000_0301, 32'h0, 32'h8765_4321, 2, 1, 0, 1, 0, 0, 2'd0, 1'b0, 32'h0000_0301, 5, 3);
        tbl[9]  = mk(4'b0000, 2'd2, 32'h0000_0400, 32'h0, 32'h55AA_55AA, 0, 1, 1, 0, 1, 0, 2'd2, 1'b0, 32'h0000_0400, 3, 1);
        tbl[10] = mk(4'b0000, 2'd0, 32'h0000_0401, 32'h0, 32'h0000_00C3, 2, 2, 0, 0, 0, 1, 2'd0, 1'b0, 32'h0000_0401, 6, 3);
        tbl[11] = mk(4'b0011, 2'd2, 32'h0000_0500, 32'h0000_BEEF, 32'h0, 0, 1, 0, 0, 0, 0, 2'd1, 1'b1, 32'h0000_0500, 3, 1);

        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_state("reset_state");
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) run_txn(tbl[i]);

        // flush in IDLE suppresses the request; stray handshakes in IDLE are ignored
        @(negedge clk);
        mem_en = 1'b1; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h600;
        flush = 1'b1; data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hFFFF_0000;
        #1;
        check("idle_flush_stall", stall_o, 1'b0);
        post_cycle("idle_flush_no_req");
        run_txn(tbl[0]);

        for (int n = 0; n < 40; n++) begin
            v.wen   = wen_set[$urandom_range(0, 9)];
            v.size  = 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.rdata = $urandom;
            v.aw    = $urandom_range(0, 4);
            v.dd    = $urandom_range(1, 4);
            v.es    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            v.fl    = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            v.fdone = (v.es > 0) && ($urandom_range(0, 1) == 1);
            v.noise = 1'($urandom_range(0, 1));
            v.exp_size  = model_size(v.wen, v.size);
            v.exp_wr    = (v.wen != 4'b0000);
            v.exp_addr  = model_addr(v.addr);
            v.exp_stall = 2 + v.aw + v.dd;
            v.exp_req   = v.aw + 1;
            run_txn(v);
        end

        // reset while the address phase is in progress abandons the transaction
        @(negedge clk);
        mem_en = 1'b1; ext_stall = 1'b0; mem_wen = 4'b0000; mem_size = 2'd2; mem_addr = 32'h700;
        @(negedge clk);
        mem_en = 1'b0;
        #1;
        check("pre_reset_req", data_req, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_txn_reset");
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0;
        run_txn(tbl[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
